workers_cpu_0_cpu_debug_host: RTL

WORKERS_CPU_0_CPU_DEBUG_HOST -- requirements
Module: workers_cpu_0_cpu_debug_host

---
 rtl/workers_cpu_0_cpu_debug_host.sv | 132 +++++++++++++
 1 files changed

// File: rtl/workers_cpu_0_cpu_debug_host.sv
// Virtual-JTAG debug host: takes one scan request, walks the debug slave through
// UIR/CDR/SDR/UDR/RTI on a divided TCK and returns the captured scan data.
module workers_cpu_0_cpu_debug_host #(
  parameter int TCK_HALF   = 2,
  parameter int SR_WIDTH   = 38,
  parameter int RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [1:0]          vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);
  localparam int PW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam int BW = $clog2(SR_WIDTH + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_UIR  = 3'd1;
  localparam logic [2:0] S_CDR  = 3'd2;
  localparam logic [2:0] S_SDR  = 3'd3;
  localparam logic [2:0] S_UDR  = 3'd4;
  localparam logic [2:0] S_RTI  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]          state;
  logic [PW-1:0]       ph_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [3:0]          rti_cnt;
  logic [1:0]          ir_q;
  logic [SR_WIDTH-1:0] tx_sr;
  logic [SR_WIDTH-1:0] cap_sr;
  logic                tck_q;

  logic accept, phase_end, tck_rise, tck_fall;
  assign accept    = cmd_valid & cmd_ready;
  assign phase_end = (ph_cnt == PW'(TCK_HALF - 1));
  assign tck_rise  = phase_end & ~tck_q;
  assign tck_fall  = phase_end & tck_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ph_cnt    <= '0;
      bit_cnt   <= '0;
      rti_cnt   <= '0;
      ir_q      <= '0;
      tx_sr     <= '0;
      cap_sr    <= '0;
      tck_q     <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            state     <= S_UIR;
            cmd_ready <= 1'b0;
            ir_q      <= cmd_ir;
            tx_sr     <= cmd_data;
            bit_cnt   <= '0;
            rti_cnt   <= '0;
            ph_cnt    <= '0;
            tck_q     <= 1'b0;
          end
        end
        S_UIR, S_CDR, S_SDR, S_UDR, S_RTI: begin
          if (phase_end) begin
            ph_cnt <= '0;
            tck_q  <= ~tck_q;
          end else begin
            ph_cnt <= ph_cnt + PW'(1);
          end
          // tdo is sampled only on TCK rising edges while shifting
          if (tck_rise && state == S_SDR) begin
            cap_sr  <= {vji_tdo, cap_sr[SR_WIDTH-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
          end
          if (tck_fall) begin
            case (state)
              S_UIR: state <= S_CDR;
              S_CDR: state <= S_SDR;
              S_SDR: begin
                if (bit_cnt == BW'(SR_WIDTH)) state <= S_UDR;
                else                           tx_sr <= tx_sr >> 1;
              end
              S_UDR: state <= S_RTI;
              S_RTI: begin
                if (rti_cnt == 4'(RTI_CYCLES - 1)) begin
                  state     <= S_DONE;
                  rsp_valid <= 1'b1;
                  rsp_data  <= cap_sr;
                end else begin
                  rti_cnt <= rti_cnt + 4'd1;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign vji_tck   = tck_q;
  assign vji_tdi   = (state == S_SDR) & tx_sr[0];
  assign vji_ir_in = (state == S_IDLE) ? 2'b00 : ir_q;
  assign vji_uir   = (state == S_UIR);
  assign vji_cdr   = (state == S_CDR);
  assign vji_sdr   = (state == S_SDR);
  assign vji_udr   = (state == S_UDR);
  assign vji_rti   = (state == S_RTI);
endmodule
